// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter execution controller.
package pc_seq_pkg;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_BRK  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one raw key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The level flips on the last of DEBOUNCE_CYCLES consecutive differing samples.
  assign accept = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      pulse <= accept && sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Execution controller: debounced keys drive HALT/RUN/BRK and produce PC write strobes.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter int                RUN_DIV         = 50_000_000,
  parameter logic [ADDR_W-1:0] PC_STEP         = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_key,
  input  logic              run_key,
  input  logic [ADDR_W-1:0] current_pc,
  input  logic              brk_en,
  input  logic [ADDR_W-1:0] brk_addr,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              running,
  output logic              brk_hit
);
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  seq_state_t        state, state_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic              skip, skip_n;
  logic              we_n;
  logic [ADDR_W-1:0] next_n;
  logic              step_p, run_p;
  logic              tick, brk_match;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .reset(reset), .key(step_key), .pulse(step_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk(clk), .reset(reset), .key(run_key), .pulse(run_p)
  );

  assign tick      = (state == ST_RUN) && (div_cnt == DIV_W'(RUN_DIV - 1));
  assign brk_match = brk_en && (current_pc == brk_addr);

  // pc_we is a one-cycle strobe; pc_next is meaningful only while pc_we=1 and
  // the PC register is expected to capture it on the following edge.
  always_comb begin
    state_n = state;
    skip_n  = skip;
    we_n    = 1'b0;
    next_n  = pc_next;
    div_n   = '0;
    if (state == ST_RUN) div_n = tick ? '0 : div_cnt + DIV_W'(1);

    if (load_req) begin
      we_n   = 1'b1;
      next_n = load_addr;
      div_n  = '0;
    end else begin
      case (state)
        ST_HALT: begin
          if (run_p) begin
            state_n = ST_RUN;
            div_n   = '0;
          end else if (step_p) begin
            we_n   = 1'b1;
            next_n = current_pc + PC_STEP;
          end
        end
        ST_RUN: begin
          if (run_p) begin
            state_n = ST_HALT;
            div_n   = '0;
          end else if (tick) begin
            if (brk_match && !skip) begin
              state_n = ST_BRK;
              div_n   = '0;
            end else begin
              we_n   = 1'b1;
              next_n = current_pc + PC_STEP;
              skip_n = 1'b0;
            end
          end
        end
        ST_BRK: begin
          if (run_p) begin
            // Resume must step past the breakpoint the PC is still parked on.
            state_n = ST_RUN;
            skip_n  = 1'b1;
            div_n   = '0;
          end else if (step_p) begin
            we_n   = 1'b1;
            next_n = current_pc + PC_STEP;
          end
        end
        default: state_n = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_HALT;
      div_cnt <= '0;
      skip    <= 1'b0;
      pc_we   <= 1'b0;
      pc_next <= '0;
      running <= 1'b0;
      brk_hit <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      skip    <= skip_n;
      pc_we   <= we_n;
      pc_next <= next_n;
      running <= (state_n == ST_RUN);
      brk_hit <= (state_n == ST_BRK);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with DEBOUNCE_CYCLES=4 and RUN_DIV=8.
module tb_pc_sequencer;
  logic        clk;
  logic        reset;
  logic        step_key;
  logic        run_key;
  logic [31:0] current_pc;
  logic        brk_en;
  logic [31:0] brk_addr;
  logic        load_req;
  logic [31:0] load_addr;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        running;
  logic        brk_hit;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int base = 0;
  int consec_bad = 0;
  logic fb_en = 1'b0;
  logic prev_we = 1'b0;
  logic prev_ld = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int at_q[$];

  pc_sequencer #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
    .clk(clk), .reset(reset), .step_key(step_key), .run_key(run_key),
    .current_pc(current_pc), .brk_en(brk_en), .brk_addr(brk_addr),
    .load_req(load_req), .load_addr(load_addr), .pc_we(pc_we),
    .pc_next(pc_next), .running(running), .brk_hit(brk_hit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge. The PC model captures pc_next.
  task automatic cyc();
    logic cur_ld;
    @(posedge clk);
    #1;
    cyc_n++;
    cur_ld = load_req;
    if (pc_we) begin
      got_q.push_back(pc_next);
      at_q.push_back(cyc_n - base);
      if (prev_we && !(cur_ld && prev_ld)) consec_bad++;
      if (fb_en) current_pc = pc_next;
    end
    prev_we = pc_we;
    prev_ld = cur_ld;
  endtask

  task automatic clear();
    got_q.delete();
    at_q.delete();
    exp_q.delete();
    base = cyc_n;
  endtask

  function automatic logic [31:0] got_at(int i);
    if (i < got_q.size()) return got_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] at_at(int i);
    if (i < at_q.size()) return 32'(at_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // driver tasks
  task automatic press_step();
    step_key = 1'b1;
    repeat (8) cyc();
    step_key = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic press_run(input int after);
    run_key = 1'b1;
    repeat (8) cyc();
    run_key = 1'b0;
    repeat (after) cyc();
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk(tag, got_at(i), exp_q[i]);
  endtask

  initial begin
    reset = 1'b1; step_key = 1'b0; run_key = 1'b0; current_pc = 32'h0;
    brk_en = 1'b0; brk_addr = 32'h0; load_req = 1'b0; load_addr = 32'h0;
    repeat (3) cyc();
    chk("rst_we", {31'd0, pc_we}, 32'd0);
    chk("rst_next", pc_next, 32'h0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_brk", {31'd0, brk_hit}, 32'd0);
    reset = 1'b0;
    cyc();

    // clean step: pulse after 2 sync + 4 stable samples, strobe one cycle later
    clear();
    step_key = 1'b1;
    repeat (12) cyc();
    step_key = 1'b0;
    repeat (8) cyc();
    exp_q.push_back(32'h4);
    check_got("step");
    chk("step_lat", at_at(0), 32'd7);

    // bouncy press settles into exactly one pulse
    clear();
    for (int i = 0; i < 10; i++) begin
      step_key = ((i % 4) < 2);
      cyc();
    end
    step_key = 1'b1;
    repeat (12) cyc();
    step_key = 1'b0;
    repeat (10) cyc();
    exp_q.push_back(32'h4);
    check_got("bounce");

    // free run with PC feedback: RUN at edge 7, advances at 15, 23, 31
    clear();
    fb_en = 1'b1;
    current_pc = 32'h0;
    press_run(23);
    chk("run_running", {31'd0, running}, 32'd1);
    exp_q = '{32'h4, 32'h8, 32'hC};
    check_got("run");
    chk("run_at0", at_at(0), 32'd15);
    chk("run_at1", at_at(1), 32'd23);
    chk("run_at2", at_at(2), 32'd31);

    // stop: HALT lands one cycle before the next tick would fire
    clear();
    press_run(20);
    chk("stop_running", {31'd0, running}, 32'd0);
    check_got("stop");

    // breakpoint at 0x8
    clear();
    current_pc = 32'h0;
    brk_en = 1'b1;
    brk_addr = 32'h8;
    press_run(32);
    exp_q = '{32'h4, 32'h8};
    check_got("brk");
    chk("brk_hit", {31'd0, brk_hit}, 32'd1);
    chk("brk_running", {31'd0, running}, 32'd0);

    clear();
    press_step();
    exp_q.push_back(32'hC);
    check_got("brk_step");
    chk("brk_step_hit", {31'd0, brk_hit}, 32'd1);

    // resume while the PC still matches: first tick advances
    clear();
    current_pc = 32'h8;
    press_run(10);
    exp_q.push_back(32'hC);
    check_got("resume");
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_brk", {31'd0, brk_hit}, 32'd0);
    press_run(10);
    brk_en = 1'b0;
    chk("resume_stop", {31'd0, running}, 32'd0);

    // load collides with a tick: single strobe, divider restarts
    clear();
    current_pc = 32'h0;
    run_key = 1'b1;
    repeat (8) cyc();
    run_key = 1'b0;
    repeat (6) cyc();
    load_req = 1'b1;
    load_addr = 32'h100;
    cyc();
    load_req = 1'b0;
    repeat (9) cyc();
    exp_q = '{32'h100, 32'h104};
    check_got("load");
    chk("load_at0", at_at(0), 32'd15);
    chk("load_at1", at_at(1), 32'd23);
    chk("load_running", {31'd0, running}, 32'd1);
    press_run(10);

    // wrap
    clear();
    fb_en = 1'b0;
    current_pc = 32'hFFFF_FFFC;
    press_step();
    exp_q.push_back(32'h0);
    check_got("wrap");

    // step and run accepted together: RUN, no strobe
    clear();
    step_key = 1'b1;
    run_key = 1'b1;
    repeat (8) cyc();
    step_key = 1'b0;
    run_key = 1'b0;
    repeat (4) cyc();
    chk("both_running", {31'd0, running}, 32'd1);
    check_got("both");

    // reset mid-RUN with a step debounce in flight
    clear();
    load_req = 1'b1;
    load_addr = 32'h200;
    cyc();
    load_req = 1'b0;
    cyc();
    exp_q.push_back(32'h200);
    check_got("pre_rst_load");
    step_key = 1'b1;
    repeat (3) cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", {31'd0, pc_we}, 32'd0);
    chk("arst_next", pc_next, 32'h0);
    chk("arst_running", {31'd0, running}, 32'd0);
    chk("arst_brk", {31'd0, brk_hit}, 32'd0);
    step_key = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    clear();
    repeat (10) cyc();
    check_got("post_rst_idle");

    clear();
    current_pc = 32'h40;
    press_step();
    exp_q.push_back(32'h44);
    check_got("post_rst_step");
    chk("post_rst_lat", at_at(0), 32'd7);

    chk("no_back_to_back", 32'(consec_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
